// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter control states: free to grant, or holding the memory for one read.
    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_e;

    // Largest supported requester count.
    localparam int MAX_PORTS = 8;

    // Width of the read-wait watchdog counter.
    localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin picker: the first set request at or after ptr+1 wins.
module rr_arb_core
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PW-1:0]        idx_o
);

    // Scan the ports in rotated order starting one past the last winner.
    always_comb begin
        logic [PW-1:0] cand;
        logic          found;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(ptr_i) + i) % NUM_PORTS);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-port memory arbiter: round-robin grants, writes complete in the grant
// cycle, a read holds the memory until data returns or the watchdog expires.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int USER_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    // requester side
    input  logic [NUM_PORTS-1:0]                   req_i,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]   wuser_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    // read return
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    output logic                                   rerr_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic [USER_WIDTH-1:0]                  ruser_o,
    // memory side
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_data_o,
    output logic [USER_WIDTH-1:0]                  mem_user_o,
    input  logic [DATA_WIDTH-1:0]                  mem_data_i,
    input  logic [USER_WIDTH-1:0]                  mem_user_i,
    input  logic                                   mem_rdata_valid_i
);

    localparam int                PW     = $clog2(NUM_PORTS);
    localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PW-1:0]        arb_idx;

    rr_arb_core #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_rr_arb_core (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // State register: pointer, read owner and watchdog, all cleared synchronously.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_PORTS - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; everything is held at zero while in reset.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        gnt_o      = '0;
        rvalid_o   = '0;
        rerr_o     = 1'b0;
        rdata_o    = '0;
        ruser_o    = '0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_be_o   = '0;
        mem_data_o = '0;
        mem_user_o = '0;

        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    // Stray read data in IDLE is deliberately not looked at.
                    if (|req_i) begin
                        gnt_o      = arb_gnt;
                        mem_req_o  = 1'b1;
                        mem_we_o   = we_i[arb_idx];
                        mem_addr_o = addr_i[arb_idx];
                        mem_be_o   = be_i[arb_idx];
                        mem_data_o = wdata_i[arb_idx];
                        mem_user_o = wuser_i[arb_idx];
                        ptr_d      = arb_idx;
                        if (!we_i[arb_idx]) begin
                            state_d = READ_WAIT;
                            owner_d = arb_idx;
                            cnt_d   = '0;
                        end
                    end
                end
                READ_WAIT: begin
                    // Real data wins over a watchdog expiry in the same cycle.
                    if (mem_rdata_valid_i) begin
                        rvalid_o[owner_q] = 1'b1;
                        rdata_o           = mem_data_i;
                        ruser_o           = mem_user_i;
                        state_d           = IDLE;
                    end else if (cnt_q == TO_LIM) begin
                        // Counter has counted TIMEOUT_CYCLES empty waits already.
                        rvalid_o[owner_q] = 1'b1;
                        rerr_o            = 1'b1;
                        state_d           = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (2 ports, watchdog of 4).
module tb_mem_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int UW = 10;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic [NP-1:0]               req_i;
    logic [NP-1:0]               we_i;
    logic [NP-1:0][AW-1:0]       addr_i;
    logic [NP-1:0][DW/8-1:0]     be_i;
    logic [NP-1:0][DW-1:0]       wdata_i;
    logic [NP-1:0][UW-1:0]       wuser_i;
    logic [NP-1:0]               gnt_o;
    logic [NP-1:0]               rvalid_o;
    logic                        rerr_o;
    logic [DW-1:0]               rdata_o;
    logic [UW-1:0]               ruser_o;
    logic                        mem_req_o;
    logic                        mem_we_o;
    logic [AW-1:0]               mem_addr_o;
    logic [DW/8-1:0]             mem_be_o;
    logic [DW-1:0]               mem_data_o;
    logic [UW-1:0]               mem_user_o;
    logic [DW-1:0]               mem_data_i;
    logic [UW-1:0]               mem_user_i;
    logic                        mem_rdata_valid_i;

    localparam logic [UW-1:0] RUSER = 10'h2C5;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .USER_WIDTH     (UW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_i             (req_i),
        .we_i              (we_i),
        .addr_i            (addr_i),
        .be_i              (be_i),
        .wdata_i           (wdata_i),
        .wuser_i           (wuser_i),
        .gnt_o             (gnt_o),
        .rvalid_o          (rvalid_o),
        .rerr_o            (rerr_o),
        .rdata_o           (rdata_o),
        .ruser_o           (ruser_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_be_o          (mem_be_o),
        .mem_data_o        (mem_data_o),
        .mem_user_o        (mem_user_o),
        .mem_data_i        (mem_data_i),
        .mem_user_i        (mem_user_i),
        .mem_rdata_valid_i (mem_rdata_valid_i)
    );

    typedef struct {
        logic          rst_n;
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic          valid;
        logic [DW-1:0] mdata;
        logic [NP-1:0] e_gnt;
        logic          e_mreq;
        logic          e_mwe;
        logic [AW-1:0] e_maddr;
        logic [NP-1:0] e_rvalid;
        logic          e_rerr;
        logic [DW-1:0] e_rdata;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(
        input logic rst_n, input logic [NP-1:0] req, input logic [NP-1:0] we,
        input logic valid, input logic [DW-1:0] mdata,
        input logic [NP-1:0] e_gnt, input logic e_mreq, input logic e_mwe,
        input logic [AW-1:0] e_maddr, input logic [NP-1:0] e_rvalid,
        input logic e_rerr, input logic [DW-1:0] e_rdata);
        vec_t v;
        v.rst_n = rst_n;   v.req = req;       v.we = we;
        v.valid = valid;   v.mdata = mdata;   v.e_gnt = e_gnt;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe;   v.e_maddr = e_maddr;
        v.e_rvalid = e_rvalid; v.e_rerr = e_rerr; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Drive one cycle of inputs, compare mid-cycle, then step past the edge.
    task automatic apply(input int tag, input vec_t v);
        logic [DW/8-1:0] e_be;
        logic [DW-1:0]   e_wd;
        logic [UW-1:0]   e_wu;
        logic [UW-1:0]   e_ru;
        rst_ni            = v.rst_n;
        req_i             = v.req;
        we_i              = v.we;
        mem_rdata_valid_i = v.valid;
        mem_data_i        = v.mdata;
        e_be = '0; e_wd = '0; e_wu = '0;
        if (v.e_gnt == 2'b01) begin e_be = 8'hFF; e_wd = 64'hA0; e_wu = 10'h001; end
        if (v.e_gnt == 2'b10) begin e_be = 8'h0F; e_wd = 64'hB1; e_wu = 10'h002; end
        e_ru = (v.e_rvalid != '0 && !v.e_rerr) ? RUSER : '0;
        @(negedge clk_i);
        check($sformatf("v%0d gnt", tag),      64'(gnt_o),      64'(v.e_gnt));
        check($sformatf("v%0d mem_req", tag),  64'(mem_req_o),  64'(v.e_mreq));
        check($sformatf("v%0d mem_we", tag),   64'(mem_we_o),   64'(v.e_mwe));
        check($sformatf("v%0d mem_addr", tag), mem_addr_o,      v.e_maddr);
        check($sformatf("v%0d mem_be", tag),   64'(mem_be_o),   64'(e_be));
        check($sformatf("v%0d mem_data", tag), mem_data_o,      e_wd);
        check($sformatf("v%0d mem_user", tag), 64'(mem_user_o), 64'(e_wu));
        check($sformatf("v%0d rvalid", tag),   64'(rvalid_o),   64'(v.e_rvalid));
        check($sformatf("v%0d rerr", tag),     64'(rerr_o),     64'(v.e_rerr));
        check($sformatf("v%0d rdata", tag),    rdata_o,         v.e_rdata);
        check($sformatf("v%0d ruser", tag),    64'(ruser_o),    64'(e_ru));
        @(posedge clk_i);
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        rst_ni            = 1'b0;
        req_i             = '0;
        we_i              = '0;
        mem_rdata_valid_i = 1'b0;
        mem_data_i        = '0;
        mem_user_i        = RUSER;
        addr_i[0] = 64'h100; addr_i[1] = 64'h80;
        be_i[0]   = 8'hFF;   be_i[1]   = 8'h0F;
        wdata_i[0] = 64'hA0; wdata_i[1] = 64'hB1;
        wuser_i[0] = 10'h001; wuser_i[1] = 10'h002;

        //          rst req    we    vld data      gnt   mreq mwe addr     rvalid err rdata
        tbl[0]  = mk(0, 2'b11, 2'b11, 0, 64'h0,    2'b00, 0, 0, 64'h0,   2'b00, 0, 64'h0);    // in reset
        tbl[1]  = mk(1, 2'b00, 2'b00, 1, 64'h1234, 2'b00, 0, 0, 64'h0,   2'b00, 0, 64'h0);    // stray valid
        tbl[2]  = mk(1, 2'b11, 2'b11, 0, 64'h0,    2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0);    // writes alternate
        tbl[3]  = mk(1, 2'b11, 2'b11, 0, 64'h0,    2'b10, 1, 1, 64'h80,  2'b00, 0, 64'h0);
        tbl[4]  = mk(1, 2'b11, 2'b11, 0, 64'h0,    2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0);
        tbl[5]  = mk(1, 2'b11, 2'b11, 0, 64'h0,    2'b10, 1, 1, 64'h80,  2'b00, 0, 64'h0);
        tbl[6]  = mk(1, 2'b01, 2'b01, 0, 64'h0,    2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0);    // ptr -> 0
        tbl[7]  = mk(1, 2'b11, 2'b01, 0, 64'h0,    2'b10, 1, 0, 64'h80,  2'b00, 0, 64'h0);    // port1 read
        tbl[8]  = mk(1, 2'b11, 2'b01, 0, 64'h0,    2'b00, 0, 0, 64'h0,   2'b00, 0, 64'h0);    // wait
        tbl[9]  = mk(1, 2'b11, 2'b01, 0, 64'h0,    2'b00, 0, 0, 64'h0,   2'b00, 0, 64'h0);
        tbl[10] = mk(1, 2'b11, 2'b01, 1, 64'hDEAD, 2'b00, 0, 0, 64'h0,   2'b10, 0, 64'hDEAD); // data back, no grant
        tbl[11] = mk(1, 2'b11, 2'b01, 0, 64'h0,    2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0);    // port0 next cycle
        tbl[12] = mk(1, 2'b00, 2'b00, 1, 64'h77,   2'b00, 0, 0, 64'h0,   2'b00, 0, 64'h0);    // late valid ignored

        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 13; i++) apply(i, tbl[i]);

        // Watchdog expiry: port0 read, four empty waits, error on the fifth.
        apply(100, mk(1, 2'b01, 2'b00, 0, 64'h0, 2'b01, 1, 0, 64'h100, 2'b00, 0, 64'h0));
        for (int k = 1; k <= 4; k++)
            apply(100 + k, mk(1, 2'b00, 2'b00, 0, 64'hFFFF, 2'b00, 0, 0, 64'h0, 2'b00, 0, 64'h0));
        apply(105, mk(1, 2'b00, 2'b00, 0, 64'hFFFF, 2'b00, 0, 0, 64'h0, 2'b01, 1, 64'h0));
        apply(106, mk(1, 2'b01, 2'b01, 0, 64'h0, 2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0));

        // Valid on the watchdog cycle: data wins, no error.
        apply(200, mk(1, 2'b01, 2'b00, 0, 64'h0, 2'b01, 1, 0, 64'h100, 2'b00, 0, 64'h0));
        for (int k = 1; k <= 4; k++)
            apply(200 + k, mk(1, 2'b00, 2'b00, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, 0, 64'h0));
        apply(205, mk(1, 2'b00, 2'b00, 1, 64'h55, 2'b00, 0, 0, 64'h0, 2'b01, 0, 64'h55));

        // Reset in the middle of a read abandons it; port 0 wins afterwards.
        apply(300, mk(1, 2'b01, 2'b00, 0, 64'h0, 2'b01, 1, 0, 64'h100, 2'b00, 0, 64'h0));
        apply(301, mk(1, 2'b00, 2'b00, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, 0, 64'h0));
        apply(302, mk(0, 2'b11, 2'b11, 0, 64'h0, 2'b00, 0, 0, 64'h0, 2'b00, 0, 64'h0));
        apply(303, mk(1, 2'b00, 2'b00, 1, 64'h99, 2'b00, 0, 0, 64'h0, 2'b00, 0, 64'h0));
        apply(304, mk(1, 2'b11, 2'b11, 0, 64'h0, 2'b01, 1, 1, 64'h100, 2'b00, 0, 64'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
